// File: rtl/platform_scan_engine.sv
// platform_scan_engine: walks the platform table one entry per cycle and accumulates collision results.
// Define PLATFORM_SCAN_LAVA_EN to build the lava-surface check; otherwise in_lava_o is tied low.
module platform_scan_engine #(
  parameter int COORD_W  = 10,
  parameter int NUM_PLAT = 12,
  parameter int IDX_W    = 4,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16,
  parameter int SNAP_TOL = 2,
  parameter int GOAL_TOL = 5,
  parameter int LAVA_Y   = 380
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [COORD_W-1:0] player_x_i,
  input  logic [COORD_W-1:0] player_y_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [IDX_W-1:0]   plat_addr_o,
  output logic               plat_rd_o,
  input  logic [COORD_W-1:0] plat_x_min_i,
  input  logic [COORD_W-1:0] plat_x_max_i,
  input  logic [COORD_W-1:0] plat_y_top_i,
  input  logic [COORD_W-1:0] plat_y_bot_i,
  input  logic               plat_valid_i,
  input  logic               plat_goal_i,
  output logic               on_ground_o,
  output logic               hit_ceiling_o,
  output logic               hit_left_wall_o,
  output logic               hit_right_wall_o,
  output logic               at_goal_region_o,
  output logic               in_lava_o,
  output logic [COORD_W-1:0] support_y_o,
  output logic [IDX_W-1:0]   support_idx_o
);
  localparam int SW = COORD_W + 2;
  typedef logic signed [SW-1:0] s_t;
  typedef enum logic [1:0] {IDLE, ISSUE, SCAN, FINISH} state_e;
  typedef struct packed {
    logic               gnd;
    logic               ceil;
    logic               lw;
    logic               rw;
    logic               goal;
    logic [COORD_W-1:0] sy;
    logic [IDX_W-1:0]   si;
  } res_t;
  state_e             state_q;
  logic [COORD_W-1:0] px_q, py_q;
  logic [IDX_W-1:0]   idx_q, addr_q;
  logic               rd_q, busy_q, done_q;
  res_t               acc_q, acc_d, res_q;
  s_t                 left, right, py_s, feet, bot, xmn, xmx, ytp, ybt;
  logic               xo, yo, take, last, rd_nxt;
  logic [IDX_W:0]     nxt2;
`ifdef PLATFORM_SCAN_LAVA_EN
  logic               lava_q;
  assign in_lava_o = lava_q;
`else
  assign in_lava_o = 1'b0;
`endif
  // Widened signed geometry keeps x_max-TOL and py+H from wrapping at the field edges.
  always_comb begin
    left  = s_t'({2'b00, px_q});
    right = left + s_t'(PLAYER_W - 1);
    py_s  = s_t'({2'b00, py_q});
    feet  = py_s + s_t'(PLAYER_H);
    bot   = feet - s_t'(1);
    xmn   = s_t'({2'b00, plat_x_min_i});
    xmx   = s_t'({2'b00, plat_x_max_i});
    ytp   = s_t'({2'b00, plat_y_top_i});
    ybt   = s_t'({2'b00, plat_y_bot_i});
    xo    = (left <= xmx) && (right >= xmn);
    yo    = (py_s <= ybt) && (bot >= ytp);
    take  = plat_valid_i && xo && (ytp <= feet) && (feet <= ytp + s_t'(SNAP_TOL)) &&
            (!acc_q.gnd || plat_y_top_i > acc_q.sy);
    acc_d      = acc_q;
    acc_d.ceil = acc_q.ceil | (plat_valid_i & xo & yo & (ybt - s_t'(SNAP_TOL) <= py_s) & (py_s <= ybt));
    acc_d.lw   = acc_q.lw | (plat_valid_i & yo & (xmx - s_t'(SNAP_TOL) <= left) & (left <= xmx));
    acc_d.rw   = acc_q.rw | (plat_valid_i & yo & (xmn <= right) & (right <= xmn + s_t'(SNAP_TOL)));
    acc_d.goal = acc_q.goal | (plat_valid_i & plat_goal_i & xo & (ytp <= feet) & (feet <= ytp + s_t'(GOAL_TOL)));
    acc_d.gnd  = acc_q.gnd | take;
    acc_d.sy   = take ? plat_y_top_i : acc_q.sy;
    acc_d.si   = take ? idx_q : acc_q.si;
    nxt2   = {1'b0, idx_q} + (IDX_W+1)'(2);
    rd_nxt = nxt2 < (IDX_W+1)'(NUM_PLAT);
    last   = idx_q == IDX_W'(NUM_PLAT - 1);
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
`ifdef PLATFORM_SCAN_LAVA_EN
      lava_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          px_q    <= player_x_i;
          py_q    <= player_y_i;
          acc_q   <= '0;
          rd_q    <= 1'b1;
          addr_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          idx_q   <= '0;
          rd_q    <= NUM_PLAT > 1;
          addr_q  <= (NUM_PLAT > 1) ? IDX_W'(1) : '0;
          state_q <= SCAN;
        end
        SCAN: begin
          acc_q  <= acc_d;
          idx_q  <= idx_q + IDX_W'(1);
          rd_q   <= rd_nxt;
          addr_q <= rd_nxt ? nxt2[IDX_W-1:0] : '0;
          if (last) begin
            res_q   <= acc_d;
            done_q  <= 1'b1;
            state_q <= FINISH;
`ifdef PLATFORM_SCAN_LAVA_EN
            lava_q  <= (feet >= s_t'(LAVA_Y)) && !acc_d.gnd;
`endif
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign plat_rd_o        = rd_q;
  assign plat_addr_o      = addr_q;
  assign on_ground_o      = res_q.gnd;
  assign hit_ceiling_o    = res_q.ceil;
  assign hit_left_wall_o  = res_q.lw;
  assign hit_right_wall_o = res_q.rw;
  assign at_goal_region_o = res_q.goal;
  assign support_y_o      = res_q.sy;
  assign support_idx_o    = res_q.si;
endmodule

// File: tb/tb_platform_scan_engine.sv
// tb_platform_scan_engine: directed and randomized scans checked against a table-level reference model.
module tb_platform_scan_engine;
  localparam int CW = 10, NP = 12, IW = 4, PW = 16, PH = 16, ST = 2, GT = 5, LY = 380;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [CW-1:0] player_x = '0, player_y = '0;
  logic busy, done, plat_rd;
  logic [IW-1:0] plat_addr;
  logic [CW-1:0] plat_x_min = '0, plat_x_max = '0, plat_y_top = '0, plat_y_bot = '0;
  logic plat_valid = 1'b0, plat_goal = 1'b0;
  logic on_ground, hit_ceiling, hit_left_wall, hit_right_wall, at_goal_region, in_lava;
  logic [CW-1:0] support_y;
  logic [IW-1:0] support_idx;
  int checks = 0, failures = 0;
  int xmn[16], xmx[16], ytp[16], ybt[16];
  bit vld[16], gol[16];
  int e_gnd, e_ceil, e_lw, e_rw, e_goal, e_lava, e_sy, e_si;

  platform_scan_engine #(.COORD_W(CW), .NUM_PLAT(NP), .IDX_W(IW), .PLAYER_W(PW), .PLAYER_H(PH),
    .SNAP_TOL(ST), .GOAL_TOL(GT), .LAVA_Y(LY)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .player_x_i(player_x), .player_y_i(player_y),
    .busy_o(busy), .done_o(done), .plat_addr_o(plat_addr), .plat_rd_o(plat_rd),
    .plat_x_min_i(plat_x_min), .plat_x_max_i(plat_x_max), .plat_y_top_i(plat_y_top),
    .plat_y_bot_i(plat_y_bot), .plat_valid_i(plat_valid), .plat_goal_i(plat_goal),
    .on_ground_o(on_ground), .hit_ceiling_o(hit_ceiling), .hit_left_wall_o(hit_left_wall),
    .hit_right_wall_o(hit_right_wall), .at_goal_region_o(at_goal_region), .in_lava_o(in_lava),
    .support_y_o(support_y), .support_idx_o(support_idx));

  always #5 clk = ~clk;

  // Level ROM: one-cycle read latency.
  always @(posedge clk)
    if (plat_rd === 1'b1) begin
      plat_x_min <= CW'(xmn[plat_addr]);
      plat_x_max <= CW'(xmx[plat_addr]);
      plat_y_top <= CW'(ytp[plat_addr]);
      plat_y_bot <= CW'(ybt[plat_addr]);
      plat_valid <= vld[plat_addr];
      plat_goal  <= gol[plat_addr];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_table();
    for (int k = 0; k < 16; k++) begin
      xmn[k] = 0; xmx[k] = 0; ytp[k] = 0; ybt[k] = 0; vld[k] = 0; gol[k] = 0;
    end
  endtask

  task automatic set_ent(input int k, input int a, input int b, input int c, input int d, input bit g);
    xmn[k] = a; xmx[k] = b; ytp[k] = c; ybt[k] = d; vld[k] = 1; gol[k] = g;
  endtask

  task automatic model(input int px, input int py);
    int feet = py + PH, bottom = py + PH - 1, l = px, r = px + PW - 1;
    int cand[$];
    bit xo, yo;
    e_gnd = 0; e_ceil = 0; e_lw = 0; e_rw = 0; e_goal = 0; e_lava = 0; e_sy = 0; e_si = 0;
    for (int k = 0; k < NP; k++) begin
      if (!vld[k]) continue;
      xo = (l <= xmx[k]) && (r >= xmn[k]);
      yo = (py <= ybt[k]) && (bottom >= ytp[k]);
      if (xo && feet >= ytp[k] && feet <= ytp[k] + ST) cand.push_back(k);
      if (xo && yo && py >= ybt[k] - ST && py <= ybt[k]) e_ceil = 1;
      if (yo && l >= xmx[k] - ST && l <= xmx[k]) e_lw = 1;
      if (yo && r >= xmn[k] && r <= xmn[k] + ST) e_rw = 1;
      if (gol[k] && xo && feet >= ytp[k] && feet <= ytp[k] + GT) e_goal = 1;
    end
    foreach (cand[i])
      if (e_gnd == 0 || ytp[cand[i]] > e_sy) begin
        e_gnd = 1; e_sy = ytp[cand[i]]; e_si = cand[i];
      end
`ifdef PLATFORM_SCAN_LAVA_EN
    e_lava = (feet >= LY && e_gnd == 0) ? 1 : 0;
`endif
  endtask

  task automatic check_res(input string tag);
    chk({tag, ".on_ground"}, 32'(on_ground), e_gnd);
    chk({tag, ".ceiling"}, 32'(hit_ceiling), e_ceil);
    chk({tag, ".left_wall"}, 32'(hit_left_wall), e_lw);
    chk({tag, ".right_wall"}, 32'(hit_right_wall), e_rw);
    chk({tag, ".goal"}, 32'(at_goal_region), e_goal);
    chk({tag, ".lava"}, 32'(in_lava), e_lava);
    chk({tag, ".support_y"}, 32'(support_y), e_sy);
    chk({tag, ".support_idx"}, 32'(support_idx), e_si);
  endtask

  // Called at a negedge with busy=0; returns at the negedge after done.
  task automatic run(input int px, input int py, input string tag, input bit poke = 0);
    int c;
    model(px, py);
    player_x = CW'(px); player_y = CW'(py); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; player_x = CW'($urandom); player_y = CW'($urandom);
    @(negedge clk);
    c = 1;
    chk({tag, ".busy_t1"}, 32'(busy), 1);
    while (done !== 1'b1 && c < 40) begin
      start = poke && (c == 4);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, c, NP + 2);
    chk({tag, ".busy_at_done"}, 32'(busy), 1);
    check_res(tag);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 0);
    chk({tag, ".busy_after"}, 32'(busy), 0);
    check_res({tag, ".hold"});
  endtask

  initial begin
    clear_table();
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.rd", 32'(plat_rd), 0);
    chk("rst.ground", 32'(on_ground), 0);
    reset = 1'b0;
    @(negedge clk);
    set_ent(1, 90, 270, 360, 380, 0);
    run(100, 344, "landing");
    chk("landing.ground_abs", 32'(on_ground), 1);
    chk("landing.sy_abs", 32'(support_y), 360);
    chk("landing.si_abs", 32'(support_idx), 1);
    clear_table();
    set_ent(3, 0, 500, 300, 310, 0);
    set_ent(5, 0, 500, 300, 310, 0);
    set_ent(7, 0, 500, 299, 310, 0);
    run(100, 285, "tie");
    chk("tie.si_abs", 32'(support_idx), 3);
    clear_table();
    set_ent(0, 240, 270, 220, 380, 0);
    run(269, 300, "lwall");
    chk("lwall.abs", 32'(hit_left_wall), 1);
    run(225, 300, "rwall");
    chk("rwall.abs", 32'(hit_right_wall), 1);
    clear_table();
    set_ent(2, 130, 200, 295, 310, 0);
    run(140, 309, "ceiling");
    chk("ceiling.abs", 32'(hit_ceiling), 1);
    clear_table();
    set_ent(0, 0, 5, 0, 1, 0);
    set_ent(4, 0, 1, 30, 40, 0);
    run(0, 0, "origin");
    clear_table();
    set_ent(0, 0, 100, 0, 5, 0);
    set_ent(1, 0, 100, 1023, 1023, 0);
    run(10, 1008, "top_edge");
    chk("top_edge.sy_abs", 32'(support_y), 1023);
    clear_table();
    set_ent(6, 580, 630, 355, 360, 1);
    run(590, 342, "goal");
    chk("goal.abs", 32'(at_goal_region), 1);
    clear_table();
    run(400, 374, "lava");
    clear_table();
    set_ent(1, 90, 270, 360, 380, 0);
    run(100, 344, "pre_reset");
    run(500, 500, "busy_start", 1);
    player_x = CW'(100); player_y = CW'(344); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid.busy", 32'(busy), 1);
    chk("mid.hold_ground", 32'(on_ground), 0);
    #2 reset = 1'b1;
    #1;
    chk("arst.busy", 32'(busy), 0);
    chk("arst.done", 32'(done), 0);
    chk("arst.rd", 32'(plat_rd), 0);
    chk("arst.addr", 32'(plat_addr), 0);
    chk("arst.flags", {26'd0, on_ground, hit_ceiling, hit_left_wall, hit_right_wall, at_goal_region, in_lava}, 0);
    chk("arst.support", {18'd0, support_y, support_idx}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(100, 344, "post_reset");
    for (int it = 0; it < 25; it++) begin
      int px = $urandom_range(60, 900), py = $urandom_range(60, 900), m;
      clear_table();
      for (int k = 0; k < NP; k++) begin
        m = $urandom_range(0, 3);
        xmn[k] = px - 40 + $urandom_range(0, 60);
        xmx[k] = xmn[k] + $urandom_range(0, 45);
        ytp[k] = py - 10 + $urandom_range(0, 30);
        ybt[k] = ytp[k] + $urandom_range(0, 30);
        if (m == 0) begin ytp[k] = py + PH - $urandom_range(0, 3); ybt[k] = ytp[k] + $urandom_range(0, 20); end
        if (m == 1) begin ybt[k] = py + $urandom_range(0, 3); ytp[k] = ybt[k] - $urandom_range(0, 20); end
        if (m == 2) begin xmx[k] = px + $urandom_range(0, 3); xmn[k] = xmx[k] - $urandom_range(0, 30); end
        if (m == 3) begin xmn[k] = px + PW - 1 - $urandom_range(0, 3); xmx[k] = xmn[k] + $urandom_range(0, 30); end
        vld[k] = $urandom_range(0, 3) != 0;
        gol[k] = $urandom_range(0, 3) == 0;
      end
      run(px, py, $sformatf("rand%0d", it));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
